// File: rtl/crc_frame_gen_if.sv
// crc_frame_gen_if: payload-in / frame-out handshake bundle for crc_frame_gen
interface crc_frame_gen_if;
   logic [47:0] inData;
   logic        inValid;
   logic        inReady;
   logic [63:0] frameOut;
   logic        outValid;
   logic        outReady;
   logic        busy;
   modport master (output inData, inValid, outReady, input inReady, frameOut, outValid, busy);
   modport slave  (input inData, inValid, outReady, output inReady, frameOut, outValid, busy);
endinterface

// File: rtl/crc_frame_gen.sv
// crc_frame_gen: builds {payload, CRC-16/XMODEM} frames one byte per clock; CRC_ERR_INJ_EN adds errInj to corrupt crc bit 0
module crc_frame_gen #(
   parameter logic [15:0] CRC_INIT = 16'h0000,
   parameter logic [15:0] CRC_POLY = 16'h1021
) (
   input logic clk,
   input logic rst,
   crc_frame_gen_if.slave bus
`ifdef CRC_ERR_INJ_EN
   ,
   input logic errInj
`endif
);
   typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;
   state_t      state, state_nxt;
   logic [47:0] payload;
   logic [15:0] crc, crc_nxt;
   logic [2:0]  byte_cnt;
   logic [7:0]  cur_byte;
   logic [63:0] frame;
   logic        out_valid;
   logic        accept, last;
   logic        inj;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
      return r;
   endfunction

   assign accept       = (state == IDLE) && bus.inValid;
   assign last         = (state == CALC) && (byte_cnt == 3'd5);
   assign cur_byte     = payload[8*(3'd5 - byte_cnt) +: 8];
   assign crc_nxt      = crc_byte(crc, cur_byte);
   assign bus.inReady  = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign bus.frameOut = frame;
   assign bus.outValid = out_valid;

   // state register; reset aborts any frame in flight
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nxt;

   // next-state: accept in IDLE, six byte steps in CALC, hold in SEND until taken
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = bus.inValid ? CALC : IDLE;
         CALC:    state_nxt = (byte_cnt == 3'd5) ? SEND : CALC;
         SEND:    state_nxt = bus.outReady ? IDLE : SEND;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef CRC_ERR_INJ_EN
   // errInj is captured with the payload so the whole frame sees one decision
   always_ff @(posedge clk or negedge rst)
      if (!rst)        inj <= 1'b0;
      else if (accept) inj <= errInj;
`else
   assign inj = 1'b0;
`endif

   // datapath: latch payload, run the CRC byte-serially, register the finished frame
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         payload   <= '0;
         crc       <= '0;
         byte_cnt  <= '0;
         frame     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_nxt == SEND);
         if (accept) begin
            payload  <= bus.inData;
            crc      <= CRC_INIT;
            byte_cnt <= '0;
         end else if (state == CALC) begin
            crc      <= crc_nxt;
            byte_cnt <= last ? 3'd0 : byte_cnt + 3'd1;
         end
         if (last) frame <= {payload, crc_nxt ^ {15'b0, inj}};
      end
endmodule

// File: tb/tb_crc_frame_gen.sv
// tb_crc_frame_gen: directed self-checking bench for crc_frame_gen
module tb_crc_frame_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   crc_frame_gen_if bus();
`ifdef CRC_ERR_INJ_EN
   logic errInj = 1'b0;
   crc_frame_gen dut (.clk(clk), .rst(rst), .bus(bus), .errInj(errInj));
`else
   crc_frame_gen dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.outValid && lat < 20);
   endtask

   task automatic offer(input logic [47:0] d, output int lat);
      bus.inData  = d;
      bus.inValid = 1'b1;
      @(posedge clk);
      #1;
      bus.inValid = 1'b0;
      wait_valid(lat);
   endtask

   task automatic test_reset;
      bus.inData   = '0;
      bus.inValid  = 1'b0;
      bus.outReady = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b want 1", bus.inReady); end
      checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", bus.outValid); end
      checks++; if (bus.frameOut !== 64'h0) begin errors++; $display("FAIL reset_frameOut got %h want 0", bus.frameOut); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_zero_payload;
      int lat;
      bus.outReady = 1'b1;
      offer(48'h0, lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL zero_latency got %0d want 6", lat); end
      checks++; if (bus.frameOut !== 64'h0) begin errors++; $display("FAIL zero_frame got %h want 0", bus.frameOut); end
      checks++; if (bus.inReady !== 1'b0) begin errors++; $display("FAIL zero_inReady_send got %b want 0", bus.inReady); end
      @(posedge clk);
      #1;
      checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL zero_taken_outValid got %b want 0", bus.outValid); end
      checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL zero_idle_inReady got %b want 1", bus.inReady); end
   endtask

   task automatic test_known_crc;
      logic [47:0] din [3] = '{48'h0000_0000_0001, 48'h0000_0000_0002, 48'h0000_0000_0100};
      logic [63:0] exp [3] = '{64'h0000_0000_0001_1021, 64'h0000_0000_0002_2042, 64'h0000_0000_0100_3331};
      int lat;
      bus.outReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         offer(din[k], lat);
         checks++; if (lat !== 6) begin errors++; $display("FAIL known_latency[%0d] got %0d want 6", k, lat); end
         checks++; if (bus.frameOut !== exp[k]) begin errors++; $display("FAIL known_frame[%0d] got %h want %h", k, bus.frameOut, exp[k]); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_pressure;
      int lat;
      bus.outReady = 1'b0;
      offer(48'h0000_0000_0002, lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL bp_latency got %0d want 6", lat); end
      bus.inData  = 48'h0000_0000_0001;
      bus.inValid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         checks++; if (bus.frameOut !== 64'h0000_0000_0002_2042) begin errors++; $display("FAIL bp_hold_frame[%0d] got %h want 0000000000022042", k, bus.frameOut); end
         checks++; if (bus.inReady !== 1'b0) begin errors++; $display("FAIL bp_hold_inReady[%0d] got %b want 0", k, bus.inReady); end
         checks++; if (bus.outValid !== 1'b1) begin errors++; $display("FAIL bp_hold_outValid[%0d] got %b want 1", k, bus.outValid); end
      end
      bus.outReady = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL bp_release_outValid got %b want 0", bus.outValid); end
      checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL bp_release_inReady got %b want 1", bus.inReady); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_no_bypass_busy got %b want 0", bus.busy); end
      @(posedge clk);
      #1;
      bus.inValid = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_pending_accept got %b want 1", bus.busy); end
      wait_valid(lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL bp_pending_latency got %0d want 6", lat); end
      checks++; if (bus.frameOut !== 64'h0000_0000_0001_1021) begin errors++; $display("FAIL bp_pending_frame got %h want 0000000000011021", bus.frameOut); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mid_reset;
      int lat;
      logic seen;
      bus.outReady = 1'b1;
      bus.inData   = 48'hABCD_EF01_2345;
      bus.inValid  = 1'b1;
      @(posedge clk);
      #1;
      bus.inValid = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_calc got %b want 1", bus.busy); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset got %b want 0", bus.busy); end
      checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL mid_outValid_reset got %b want 0", bus.outValid); end
      checks++; if (bus.frameOut !== 64'h0) begin errors++; $display("FAIL mid_frame_reset got %h want 0", bus.frameOut); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.outValid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_emit got %b want 0", seen); end
      offer(48'h0000_0000_0001, lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL mid_after_latency got %0d want 6", lat); end
      checks++; if (bus.frameOut !== 64'h0000_0000_0001_1021) begin errors++; $display("FAIL mid_after_frame got %h want 0000000000011021", bus.frameOut); end
      @(posedge clk);
      #1;
   endtask

`ifdef CRC_ERR_INJ_EN
   task automatic test_err_inj;
      int lat;
      bus.outReady = 1'b1;
      errInj = 1'b1;
      offer(48'h0000_0000_0001, lat);
      checks++; if (bus.frameOut !== 64'h0000_0000_0001_1020) begin errors++; $display("FAIL errinj_on got %h want 0000000000011020", bus.frameOut); end
      @(posedge clk);
      #1;
      errInj = 1'b0;
      offer(48'h0000_0000_0001, lat);
      checks++; if (bus.frameOut !== 64'h0000_0000_0001_1021) begin errors++; $display("FAIL errinj_off got %h want 0000000000011021", bus.frameOut); end
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      test_reset();
      test_zero_payload();
      test_known_crc();
      test_back_pressure();
      test_mid_reset();
`ifdef CRC_ERR_INJ_EN
      test_err_inj();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/crc_frame_gen.md
# crc_frame_gen

- Transmit-side frame builder for the bus comparator path.
- Accepts a 48-bit payload and computes CRC-16/XMODEM over it, one byte per clock.
- Emits a 64-bit frame: payload in bits [63:16], CRC in bits [15:0]. This is the format the receive-side CRC checker and the 48-bit data comparator consume.
- Sits between the payload source and the redundant bus drivers. Uses valid/ready handshakes on both sides.

## Interface
- `CRC_INIT`, default 16'h0000: CRC register start value for each frame.
- `CRC_POLY`, default 16'h1021: generator polynomial, non-reflected, no final XOR.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low (asserted when 0).
- `inData`  input  48  payload; byte [47:40] is sent first.
- `inValid`  input  1  payload offer.
- `inReady`  output  1  block can accept a payload.
- `frameOut`  output  64  built frame {payload, crc}.
- `outValid`  output  1  `frameOut` is valid.
- `outReady`  input  1  downstream accepts the frame.
- `busy`  output  1  a frame is in CALC or SEND.

## Operation
- State machine:
  - IDLE: `inReady`=1. On `inValid`&&`inReady`, latch `inData` into the payload register, load crc=`CRC_INIT`, clear byteCnt to 0, go to CALC.
  - CALC: each cycle, XOR byte[byteCnt] (MSB byte first) into crc[15:8], then apply 8 polynomial shift steps combinationally. Increment byteCnt. After byteCnt=5 is processed, go to SEND.
  - SEND: `outValid`=1 and `frameOut`={payload, crc}. On `outReady`, go to IDLE.
- `frameOut` and `outValid` come from registers. `frameOut` stays constant while `outValid`=1 and `outReady`=0.
- byteCnt is 3 bits and never exceeds 5; its value outside CALC is don't-care.
- `inReady`=1 only in IDLE. A payload offered in any other state stays pending until the block returns to IDLE.
- Shift step: if crc[15]=1, crc=(crc<<1)^`CRC_POLY`; otherwise crc=crc<<1. Keep 16 bits and drop the carry.
- `busy` = (state != IDLE).
- Reset asserted at any time, including mid-CALC or mid-SEND:
  - Go to IDLE immediately; the partial frame is discarded and is never emitted.
  - `outValid`=0, `frameOut`=0, `busy`=0, `inReady`=1 once reset is released.
  - Payload and crc registers are cleared to 0.

## Timing
- Reset values: `inReady`=1, `outValid`=0, `frameOut`=64'h0, `busy`=0.
- Accept on edge N, CALC on edges N+1..N+6, `outValid` high after edge N+6. Accept-to-valid latency is 6 cycles.
- If `outReady` is high when `outValid` rises, the frame is taken that same cycle. The block is back in IDLE after edge N+7.
- Throughput is one frame per 8 cycles when no back-pressure is applied.
- There is no bypass: an accept cannot occur in the same cycle as an output handshake.

## Configuration
- `CRC_ERR_INJ_EN` defined:
  - Adds input port `errInj` (1 bit). `errInj` is sampled at the accept handshake.
  - If the sampled value is 1, crc bit 0 is inverted when the frame is loaded into `frameOut`. This produces a deliberately bad CRC for exercising the downstream checker and comparator.
- `CRC_ERR_INJ_EN` not defined:
  - The port is absent and the CRC is always correct.

## Test plan
- Reset behaviour: hold `rst`=0 for 3 cycles, then release → `inReady`=1, `outValid`=0, `frameOut`=64'h0.
- Zero payload: offer `inData`=48'h0 with `outReady`=1 → `outValid` rises 6 cycles after accept; `frameOut`=64'h0000_0000_0000_0000.
- Known CRC values:
  - `inData`=48'h0000_0000_0001 → `frameOut`=64'h0000_0000_0001_1021.
  - `inData`=48'h0000_0000_0002 → `frameOut`=64'h0000_0000_0002_2042.
- Back-pressure: hold `outReady`=0 for 10 cycles after `outValid` rises → `frameOut` stays stable and `inReady`=0 throughout. Raise `outReady` → one handshake, then `inReady`=1 on the next cycle.
- Mid-operation reset: assert `rst`=0 on the 3rd CALC cycle → `busy`=0 and `outValid` never asserts for that frame. A following frame with payload 48'h1 produces CRC 16'h1021.
- With `CRC_ERR_INJ_EN` defined: `inData`=48'h1 with `errInj`=1 → `frameOut`=64'h0000_0000_0001_1020. With `errInj`=0 → CRC 16'h1021.
